// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline stall/flush sequencer and the datapath.
// master drives the hazard/branch/memory/halt events; slave returns stage controls.
interface pipeline_ctrl_if;
  logic       hazard;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_ack;
  logic       halt_req;
  logic       resume;
  logic       pc_en;
  logic       pc_sel;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_m_en;
  logic       m_wb_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       halted;
  logic       mem_timeout_err;
  logic [7:0] stall_cnt;

  modport master (
    output hazard, branch_taken, mem_req, mem_ack, halt_req, resume,
    input  pc_en, pc_sel, if_id_en, id_ex_en, ex_m_en, m_wb_en,
           if_id_flush, id_ex_flush, halted, mem_timeout_err, stall_cnt
  );

  modport slave (
    input  hazard, branch_taken, mem_req, mem_ack, halt_req, resume,
    output pc_en, pc_sel, if_id_en, id_ex_en, ex_m_en, m_wb_en,
           if_id_flush, id_ex_flush, halted, mem_timeout_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage enables, bubbles,
// PC select, halt/drain sequence, data-memory watchdog and stall counter.
//
// state    | meaning
// RUN      | normal issue; hazard, branch and halt resolved combinationally
// MEM_WAIT | whole pipeline frozen on an outstanding data-RAM access
// DRAIN    | front end stalled while EX/M/WB empty out before halting
// HALTED   | core stopped until resume
// ERR      | memory watchdog tripped; only reset leaves
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input logic            clk,
  input logic            rst_n,
  pipeline_ctrl_if.slave bus
);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0]   WAIT_LAST  = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {RUN, MEM_WAIT, DRAIN, HALTED, ERR} state_t;

  state_t             state, state_nxt, saved, saved_nxt, eff;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nxt;
  logic [7:0]         stall_q;
  logic               mem_stall;

  assign mem_stall = bus.mem_req & ~bus.mem_ack;
  // On the ack cycle the saved state's outputs apply, so a frozen branch is honoured.
  assign eff = (state == MEM_WAIT && bus.mem_ack) ? saved : state;
  assign bus.stall_cnt = stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      saved     <= RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
      stall_q   <= '0;
    end else begin
      state     <= state_nxt;
      saved     <= saved_nxt;
      wait_cnt  <= wait_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (!bus.pc_en && state != HALTED && state != ERR && stall_q != 8'hFF)
        stall_q <= stall_q + 8'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    saved_nxt     = saved;
    wait_cnt_nxt  = wait_cnt;
    drain_cnt_nxt = drain_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          saved_nxt    = RUN;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end else if (!bus.branch_taken && !bus.hazard && bus.halt_req) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack) begin
          state_nxt = saved;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
          if (wait_cnt >= WAIT_LAST) state_nxt = ERR;
        end
      end
      DRAIN: begin
        if (mem_stall) begin
          saved_nxt    = DRAIN;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end else if (drain_cnt >= DRAIN_LAST) begin
          state_nxt = HALTED;
        end else begin
          drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
        end
      end
      HALTED: if (bus.resume) state_nxt = RUN;
      ERR: state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    bus.pc_en           = 1'b0;
    bus.pc_sel          = 1'b0;
    bus.if_id_en        = 1'b0;
    bus.id_ex_en        = 1'b0;
    bus.ex_m_en         = 1'b0;
    bus.m_wb_en         = 1'b0;
    bus.if_id_flush     = 1'b0;
    bus.id_ex_flush     = 1'b0;
    bus.halted          = 1'b0;
    bus.mem_timeout_err = 1'b0;
    case (eff)
      RUN: begin
        if (!mem_stall) begin
          bus.id_ex_en = 1'b1;
          bus.ex_m_en  = 1'b1;
          bus.m_wb_en  = 1'b1;
          if (bus.branch_taken) begin
            bus.pc_en       = 1'b1;
            bus.pc_sel      = 1'b1;
            bus.if_id_en    = 1'b1;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
          end else if (bus.hazard || bus.halt_req) begin
            bus.id_ex_flush = 1'b1;
          end else begin
            bus.pc_en    = 1'b1;
            bus.if_id_en = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!mem_stall) begin
          bus.id_ex_en    = 1'b1;
          bus.ex_m_en     = 1'b1;
          bus.m_wb_en     = 1'b1;
          bus.id_ex_flush = 1'b1;
        end
      end
      HALTED:  bus.halted = 1'b1;
      ERR:     bus.mem_timeout_err = 1'b1;
      default: bus.halted = 1'b0;
    endcase
    if (!rst_n) begin
      bus.pc_en           = 1'b0;
      bus.pc_sel          = 1'b0;
      bus.if_id_en        = 1'b0;
      bus.id_ex_en        = 1'b0;
      bus.ex_m_en         = 1'b0;
      bus.m_wb_en         = 1'b0;
      bus.if_id_flush     = 1'b0;
      bus.id_ex_flush     = 1'b0;
      bus.halted          = 1'b0;
      bus.mem_timeout_err = 1'b0;
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected controls and stall counts are
// queued per stimulus cycle and compared against the sampled DUT outputs.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus();

  pipeline_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4), .DRAIN_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ctl = {pc_en, pc_sel, if_id_en, id_ex_en, ex_m_en, m_wb_en, if_id_flush, id_ex_flush, halted, err}
  localparam logic [9:0] C_RUN    = 10'b1011110000;
  localparam logic [9:0] C_STALL  = 10'b0001110100;
  localparam logic [9:0] C_BRANCH = 10'b1111111100;
  localparam logic [9:0] C_FREEZE = 10'b0000000000;
  localparam logic [9:0] C_HALTED = 10'b0000000010;
  localparam logic [9:0] C_ERR    = 10'b0000000001;

  // stim = {hazard, branch_taken, mem_req, mem_ack, halt_req, resume}
  localparam logic [5:0] IN_IDLE    = 6'b000000;
  localparam logic [5:0] IN_HZ      = 6'b100000;
  localparam logic [5:0] IN_BR_ALL  = 6'b110010;
  localparam logic [5:0] IN_MR_BR   = 6'b011000;
  localparam logic [5:0] IN_ACK_BR  = 6'b011100;
  localparam logic [5:0] IN_MR      = 6'b001000;
  localparam logic [5:0] IN_MR_ACK  = 6'b001100;
  localparam logic [5:0] IN_HLT     = 6'b000010;
  localparam logic [5:0] IN_RES     = 6'b000001;
  localparam logic [5:0] IN_ACK_RES = 6'b001101;

  typedef struct {
    string      name;
    logic [9:0] ctl;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [9:0] obs_ctl;
  logic [7:0] obs_cnt;

  // Expected stall count advances whenever the expected cycle stalls the PC outside HALTED/ERR.
  function automatic void push_exp(input string name, input logic [9:0] ctl);
    sb.push_back('{name, ctl, exp_cnt});
    if (!ctl[9] && !ctl[1] && !ctl[0] && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
  endfunction

  task automatic sample();
    obs_ctl = {bus.pc_en, bus.pc_sel, bus.if_id_en, bus.id_ex_en, bus.ex_m_en, bus.m_wb_en,
               bus.if_id_flush, bus.id_ex_flush, bus.halted, bus.mem_timeout_err};
    obs_cnt = bus.stall_cnt;
  endtask

  task automatic drive(input logic [5:0] stim);
    @(negedge clk);
    {bus.hazard, bus.branch_taken, bus.mem_req, bus.mem_ack, bus.halt_req, bus.resume} = stim;
    #2;
    sample();
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    drive(IN_HZ);
    sb.push_back('{"reset_outputs", C_FREEZE, 8'd0});
    e = sb.pop_front();
    checks++;
    if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
      failures++;
      $display("FAIL %s: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, obs_ctl, obs_cnt, e.ctl, e.cnt);
    end
    @(negedge clk);
    {bus.hazard, bus.branch_taken, bus.mem_req, bus.mem_ack, bus.halt_req, bus.resume} = IN_IDLE;
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    push_exp("reset_release", C_RUN);
    drive(IN_IDLE);
    e = sb.pop_front();
    checks++;
    if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
      failures++;
      $display("FAIL %s: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, obs_ctl, obs_cnt, e.ctl, e.cnt);
    end
  endtask

  task automatic test_load_use();
    logic [15:0] t[$];
    exp_t e;
    t = '{{IN_HZ, C_STALL}, {IN_IDLE, C_RUN}, {IN_HZ, C_STALL}, {IN_HZ, C_STALL}, {IN_IDLE, C_RUN}};
    foreach (t[i]) begin
      push_exp("load_use", t[i][9:0]);
      drive(t[i][15:10]);
      e = sb.pop_front();
      checks++;
      if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s[%0d]: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, i, obs_ctl, obs_cnt, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_branch_priority();
    logic [15:0] t[$];
    exp_t e;
    t = '{{IN_BR_ALL, C_BRANCH}, {IN_IDLE, C_RUN}, {IN_MR_BR, C_FREEZE},
          {IN_ACK_BR, C_BRANCH}, {IN_IDLE, C_RUN}};
    foreach (t[i]) begin
      push_exp("branch_priority", t[i][9:0]);
      drive(t[i][15:10]);
      e = sb.pop_front();
      checks++;
      if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s[%0d]: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, i, obs_ctl, obs_cnt, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [15:0] t[$];
    exp_t e;
    t = '{{IN_MR, C_FREEZE}, {IN_MR, C_FREEZE}, {IN_MR, C_FREEZE}, {IN_MR_ACK, C_RUN},
          {IN_IDLE, C_RUN}, {IN_MR_ACK, C_RUN}, {IN_IDLE, C_RUN}};
    foreach (t[i]) begin
      push_exp("mem_wait", t[i][9:0]);
      drive(t[i][15:10]);
      e = sb.pop_front();
      checks++;
      if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s[%0d]: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, i, obs_ctl, obs_cnt, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_halt();
    logic [15:0] t[$];
    exp_t e;
    t = '{{IN_HLT, C_STALL}, {IN_IDLE, C_STALL}, {IN_IDLE, C_STALL}, {IN_IDLE, C_HALTED},
          {IN_MR, C_HALTED}, {IN_IDLE, C_HALTED}, {IN_RES, C_HALTED}, {IN_IDLE, C_RUN}};
    foreach (t[i]) begin
      push_exp("halt", t[i][9:0]);
      drive(t[i][15:10]);
      e = sb.pop_front();
      checks++;
      if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s[%0d]: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, i, obs_ctl, obs_cnt, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_drain_mem();
    logic [15:0] t[$];
    exp_t e;
    t = '{{IN_HLT, C_STALL}, {IN_MR, C_FREEZE}, {IN_MR, C_FREEZE}, {IN_MR_ACK, C_STALL},
          {IN_IDLE, C_STALL}, {IN_IDLE, C_STALL}, {IN_IDLE, C_HALTED}, {IN_RES, C_HALTED},
          {IN_IDLE, C_RUN}};
    foreach (t[i]) begin
      push_exp("drain_mem", t[i][9:0]);
      drive(t[i][15:10]);
      e = sb.pop_front();
      checks++;
      if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s[%0d]: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, i, obs_ctl, obs_cnt, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] t[$];
    exp_t e;
    for (int k = 0; k < 15; k++) t.push_back({IN_MR, C_FREEZE});
    t.push_back({IN_ACK_RES, C_ERR});
    t.push_back({IN_IDLE, C_ERR});
    t.push_back({IN_RES, C_ERR});
    foreach (t[i]) begin
      push_exp("timeout", t[i][9:0]);
      drive(t[i][15:10]);
      e = sb.pop_front();
      checks++;
      if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s[%0d]: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, i, obs_ctl, obs_cnt, e.ctl, e.cnt);
      end
    end
    @(negedge clk);
    {bus.hazard, bus.branch_taken, bus.mem_req, bus.mem_ack, bus.halt_req, bus.resume} = IN_IDLE;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    push_exp("timeout_cleared", C_RUN);
    drive(IN_IDLE);
    e = sb.pop_front();
    checks++;
    if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
      failures++;
      $display("FAIL %s: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, obs_ctl, obs_cnt, e.ctl, e.cnt);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      push_exp("reset_mid_wait", C_FREEZE);
      drive(IN_MR);
      e = sb.pop_front();
      checks++;
      if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s[%0d]: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, k, obs_ctl, obs_cnt, e.ctl, e.cnt);
      end
    end
    #1;
    bus.hazard = 1'b1;
    bus.branch_taken = 1'b1;
    rst_n = 1'b0;
    #1;
    sample();
    sb.push_back('{"reset_mid_async", C_FREEZE, 8'd0});
    e = sb.pop_front();
    checks++;
    if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
      failures++;
      $display("FAIL %s: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, obs_ctl, obs_cnt, e.ctl, e.cnt);
    end
    @(negedge clk);
    {bus.hazard, bus.branch_taken, bus.mem_req, bus.mem_ack, bus.halt_req, bus.resume} = IN_IDLE;
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    for (int k = 0; k < 2; k++) begin
      push_exp("reset_mid_release", C_RUN);
      drive(IN_IDLE);
      e = sb.pop_front();
      checks++;
      if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s[%0d]: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, k, obs_ctl, obs_cnt, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_saturate();
    logic [15:0] t[$];
    exp_t e;
    for (int k = 0; k < 258; k++) t.push_back({IN_HZ, C_STALL});
    t.push_back({IN_IDLE, C_RUN});
    foreach (t[i]) begin
      push_exp("stall_saturate", t[i][9:0]);
      drive(t[i][15:10]);
      e = sb.pop_front();
      checks++;
      if (obs_ctl !== e.ctl || obs_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s[%0d]: ctl=%b stall_cnt=%0d, expected ctl=%b stall_cnt=%0d", e.name, i, obs_ctl, obs_cnt, e.ctl, e.cnt);
      end
    end
  endtask

  initial begin
    {bus.hazard, bus.branch_taken, bus.mem_req, bus.mem_ack, bus.halt_req, bus.resume} = IN_IDLE;
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_halt();
    test_drain_mem();
    test_timeout();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d expected completion", checks);
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage 10-bit CPU pipeline (IF, ID, EX, M, WB). It turns the hazard unit's stall request, EX-stage branch resolution, data-RAM handshake and halt instructions into per-stage register enables, bubble/flush controls and the PC mux select. It also owns the halt/drain sequence, a data-memory timeout watchdog and a stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 15, number of consecutive MEM_WAIT cycles without mem_ack before the error trap; range 1..(2^CNT_W)-1.
CNT_W, 4, width of the memory-wait counter.
DRAIN_CYCLES, 3, cycles spent draining EX/M/WB before HALTED.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
hazard  in  1  stall request from hazard detection: load-use or branch-operand dependency.
branch_taken  in  1  branch/jump resolved taken in EX, valid this cycle.
mem_req  in  1  instruction in M stage accesses data RAM.
mem_ack  in  1  data RAM completes access this cycle.
halt_req  in  1  halt instruction present in ID.
resume  in  1  external restart from HALTED.
pc_en  out  1  PC register load enable.
pc_sel  out  1  1 = load branch target, 0 = PC+1.
if_id_en, id_ex_en, ex_m_en, m_wb_en  out  1 each  pipeline register enables.
if_id_flush, id_ex_flush  out  1 each  load NOP into that register (when its enable is 1).
halted  out  1  core halted.
mem_timeout_err  out  1  sticky watchdog error.
stall_cnt  out  8  saturating count of stall cycles.

Behaviour:
- State register states: RUN, MEM_WAIT, DRAIN, HALTED, ERR. State updates on posedge clk. Outputs are combinational from the state and current inputs.
- Reset (rst_n low, asynchronous):
  - state = RUN; wait counter = 0; drain counter = 0; saved state = RUN; stall_cnt = 0.
  - While rst_n is low, all outputs are forced to 0.
- Default output (RUN, no event): every enable = 1, both flushes = 0, pc_sel = 0.
- RUN priority, highest first:
  1. mem_req & !mem_ack: all enables = 0. Save RUN as the return state; next state = MEM_WAIT; wait counter = 1.
  2. branch_taken: pc_en = 1, pc_sel = 1, if_id_flush = 1, id_ex_flush = 1, all enables = 1. Any concurrent hazard or halt_req is ignored because that instruction is squashed.
  3. hazard: pc_en = 0, if_id_en = 0, id_ex_flush = 1. Other enables = 1, which inserts one bubble. Repeats each cycle hazard stays high.
  4. halt_req: same outputs as hazard; next state = DRAIN; drain counter = 1.
- mem_req & mem_ack in the same cycle (any state except HALTED/ERR): no wait; normal outputs.
- MEM_WAIT:
  - All enables = 0 and flushes = 0.
  - When mem_ack arrives: outputs are those of the saved state for that cycle, and next state = saved state.
  - Otherwise the wait counter increments. If the counter equals MEM_TIMEOUT and ack is still absent, next state = ERR.
  - A branch held in the frozen EX stage is acted on after return.
- DRAIN:
  - pc_en = 0, if_id_en = 0, id_ex_flush = 1; EX/M/WB enabled.
  - A memory stall here enters MEM_WAIT with saved state DRAIN. The drain counter is held during the wait.
  - When the counter reaches DRAIN_CYCLES: next state = HALTED.
  - branch_taken is not possible in DRAIN (bubbles only), so it is ignored.
- HALTED: all enables = 0 and halted = 1. resume leads to RUN on the next edge, where enables return to 1.
- ERR: all enables = 0 and mem_timeout_err = 1. Only reset exits ERR.
- stall_cnt:
  - Increments by 1 on every clock edge where pc_en = 0 and the state is not HALTED or ERR.
  - Saturates at 255; no wrap.
- Reset mid-sequence (any state) returns immediately to RUN with all counters cleared.

Test Plan:
- Load-use: hazard = 1 for 1 cycle in RUN -> that cycle pc_en = 0, if_id_en = 0, id_ex_flush = 1, ex_m_en = 1. Next cycle all enables = 1; stall_cnt = 1.
- Branch + hazard same cycle -> pc_sel = 1, pc_en = 1, if_id_flush = id_ex_flush = 1, no stall. stall_cnt unchanged.
- mem_req held, mem_ack after 3 cycles -> 3 cycles all enables = 0. Ack cycle all enables = 1; state RUN; stall_cnt = 3.
- mem_req held, no ack (MEM_TIMEOUT = 15) -> ERR after the 15th wait cycle; mem_timeout_err = 1 sticky. The late mem_ack and resume are ignored; rst_n pulse clears it.
- halt_req in RUN -> 3 DRAIN cycles (pc_en = 0, id_ex_flush = 1), then halted = 1. resume -> RUN next cycle; stall_cnt = 3.
- rst_n low during MEM_WAIT -> outputs 0 immediately. After release: state RUN, all enables = 1, stall_cnt = 0.
